// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD arbiter slice.
// Imported by the arbiter top and its round-robin picker.
package lcd_pkg;

  localparam int LCD_ROW_W     = 128;
  localparam int START_TMO_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    FINISH
  } state_t;

endpackage

// File: rtl/lcd_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder.
// Searches req from rr_ptr upward with wrap; first set bit wins.
module rr_picker
  import lcd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    idx
);

  logic [N_REQ-1:0] rot;
  logic [PW:0]      sum;
  logic             hit;

  always_comb begin
    rot = N_REQ'({req, req} >> rr_ptr);
    idx = '0;
    sum = '0;
    hit = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!hit && rot[k]) begin
        hit = 1'b1;
        sum = {1'b0, rr_ptr} + (PW+1)'(k);
        // rotated offset maps back onto the physical requester index
        if (sum >= (PW+1)'(N_REQ))
          sum = sum - (PW+1)'(N_REQ);
        idx = sum[PW-1:0];
      end
    end
    grant = '0;
    for (int i = 0; i < N_REQ; i++)
      grant[i] = hit && (idx == PW'(i));
  end

endmodule

// File: rtl/lcd_arbiter.sv
// lcd_arbiter: shares one LCD driver among N_REQ frame requesters.
// Round-robin grant, latched frame, single ena, busy tracking, timeout.
module lcd_arbiter
  import lcd_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int START_TMO = START_TMO_DEF,
  parameter int PW        = 2
) (
  input  logic                       clk_1MHz,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*LCD_ROW_W-1:0] row1_in,
  input  logic [N_REQ*LCD_ROW_W-1:0] row2_in,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           done,
  output logic                       err_tmo,
  output logic                       lcd_ena,
  output logic [LCD_ROW_W-1:0]       lcd_row1,
  output logic [LCD_ROW_W-1:0]       lcd_row2,
  input  logic                       lcd_busy
);

  localparam int CW = $clog2(START_TMO + 1);

  state_t               state, state_nx;
  logic [N_REQ-1:0]     grant_nx;
  logic [PW-1:0]        owner, owner_nx;
  logic [PW-1:0]        rr_ptr, ptr_nx;
  logic [LCD_ROW_W-1:0] row1_nx, row2_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic                 err_flag, err_nx;

  logic [N_REQ-1:0]     pick_grant;
  logic [PW-1:0]        pick_idx;

  logic [LCD_ROW_W-1:0] r1s [N_REQ];
  logic [LCD_ROW_W-1:0] r2s [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_split
    assign r1s[g] = row1_in[g*LCD_ROW_W +: LCD_ROW_W];
    assign r2s[g] = row2_in[g*LCD_ROW_W +: LCD_ROW_W];
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx)
  );

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    owner_nx = owner;
    ptr_nx   = rr_ptr;
    row1_nx  = lcd_row1;
    row2_nx  = lcd_row2;
    cnt_nx   = cnt;
    err_nx   = err_flag;
    lcd_ena  = 1'b0;
    done     = '0;
    err_tmo  = 1'b0;
    unique case (state)
      IDLE: begin
        // a still-busy driver (prior abort) holds off arbitration
        if (|req && !lcd_busy) begin
          state_nx = START;
          grant_nx = pick_grant;
          owner_nx = pick_idx;
          row1_nx  = r1s[pick_idx];
          row2_nx  = r2s[pick_idx];
        end
      end
      START: begin
        lcd_ena  = 1'b1;
        cnt_nx   = '0;
        state_nx = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (lcd_busy) begin
          state_nx = WAIT_DONE;
        end else if (cnt == CW'(START_TMO - 1)) begin
          state_nx = FINISH;
          err_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!lcd_busy)
          state_nx = FINISH;
      end
      FINISH: begin
        done     = grant;
        err_tmo  = err_flag;
        grant_nx = '0;
        err_nx   = 1'b0;
        ptr_nx   = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_1MHz) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      lcd_row1 <= '0;
      lcd_row2 <= '0;
      cnt      <= '0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      owner    <= owner_nx;
      rr_ptr   <= ptr_nx;
      lcd_row1 <= row1_nx;
      lcd_row2 <= row2_nx;
      cnt      <= cnt_nx;
      err_flag <= err_nx;
    end
  end

endmodule

// File: tb/tb_lcd_arbiter.sv
// tb_lcd_arbiter: scoreboard bench for lcd_arbiter with a busy-driver model.
// Expected frames/owners are queued at stimulus time, popped on done.
module tb_lcd_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;
  localparam int W   = 128;

  logic             clk_1MHz = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   row1_in, row2_in;
  logic [N-1:0]     grant, done;
  logic             err_tmo, lcd_ena;
  logic [W-1:0]     lcd_row1, lcd_row2;
  logic             lcd_busy = 1'b0;

  logic [W-1:0] r1 [N];
  logic [W-1:0] r2 [N];
  assign row1_in = {r1[3], r1[2], r1[1], r1[0]};
  assign row2_in = {r2[3], r2[2], r2[1], r2[0]};

  typedef struct {
    logic [N-1:0] d;
    logic         e;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t sbq[$];
  exp_t x;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int pend [N] = '{default: 0};
  int ena_cnt = 0, dn_cnt = 0;
  int ena_cyc = 0, done_cyc = 0, fall_cyc = 0, req_cyc = 0;
  int busy_len = 200, bcnt = 0;
  bit mute = 1'b0;
  logic prev_busy = 1'b0;
  logic [N-1:0] nreq;
  int e0, d0;

  localparam logic [W-1:0] HELLO = "HELLO           ";
  localparam logic [W-1:0] WORLD = "WORLD           ";

  lcd_arbiter #(
    .N_REQ     (N),
    .START_TMO (TMO),
    .PW        (2)
  ) dut (
    .clk_1MHz (clk_1MHz),
    .rst_n    (rst_n),
    .req      (req),
    .row1_in  (row1_in),
    .row2_in  (row2_in),
    .grant    (grant),
    .done     (done),
    .err_tmo  (err_tmo),
    .lcd_ena  (lcd_ena),
    .lcd_row1 (lcd_row1),
    .lcd_row2 (lcd_row2),
    .lcd_busy (lcd_busy)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  always @(posedge clk_1MHz) cyc <= cyc + 1;

  // driver model: busy for busy_len cycles after each ena, unless muted
  always @(posedge clk_1MHz) begin
    if (lcd_ena && !mute) begin
      lcd_busy <= 1'b1;
      bcnt     <= busy_len;
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else if (bcnt == 1) begin
      bcnt     <= 0;
      lcd_busy <= 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] i, input logic e);
    exp_t t;
    t.d = 4'b0001 << i;
    t.e = e;
    t.a = r1[i];
    t.b = r2[i];
    sbq.push_back(t);
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while (sbq.size() != 0 && n < lim) begin
      @(negedge clk_1MHz);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", W'(sbq.size()), W'(0));
      sbq.delete();
    end
    repeat (2) @(negedge clk_1MHz);
  endtask

  task automatic wait_ena(input int base, input int lim);
    int n = 0;
    while (ena_cnt == base && n < lim) begin
      @(negedge clk_1MHz);
      n++;
    end
    if (ena_cnt == base) chk("ena_timeout", W'(0), W'(1));
  endtask

  task automatic wait_busy(input int lim);
    int n = 0;
    while (!lcd_busy && n < lim) begin
      @(negedge clk_1MHz);
      n++;
    end
    if (!lcd_busy) chk("busy_timeout", W'(0), W'(1));
  endtask

  // monitor + requester model; requests held until their done
  initial begin
    forever begin
      @(negedge clk_1MHz);
      if (lcd_ena) begin
        ena_cnt++;
        ena_cyc = cyc;
        if (sbq.size() != 0) begin
          chk("ena_grant", W'(grant), W'(sbq[0].d));
          chk("ena_row1", lcd_row1, sbq[0].a);
          chk("ena_row2", lcd_row2, sbq[0].b);
        end
      end
      if (done != '0) begin
        dn_cnt++;
        done_cyc = cyc;
        if (sbq.size() == 0) begin
          chk("done_unexp", W'(done), W'(0));
        end else begin
          x = sbq.pop_front();
          chk("done_owner", W'(done), W'(x.d));
          chk("done_err", W'(err_tmo), W'(x.e));
          chk("done_row1", lcd_row1, x.a);
          chk("done_row2", lcd_row2, x.b);
        end
        for (int i = 0; i < N; i++)
          if (done[i] && pend[i] > 0) pend[i]--;
      end else if (err_tmo) begin
        chk("err_alone", W'(err_tmo), W'(0));
      end
      if (prev_busy && !lcd_busy) fall_cyc = cyc;
      prev_busy = lcd_busy;
      for (int i = 0; i < N; i++) nreq[i] = (pend[i] > 0);
      if (req == '0 && nreq != '0) req_cyc = cyc;
      req = nreq;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      r1[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      r2[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    r1[0] = HELLO;
    repeat (3) @(negedge clk_1MHz);
    chk("rst_grant", W'(grant), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_err", W'(err_tmo), W'(0));
    chk("rst_ena", W'(lcd_ena), W'(0));
    chk("rst_row1", lcd_row1, W'(0));
    chk("rst_row2", lcd_row2, W'(0));
    rst_n = 1'b1;
    @(negedge clk_1MHz);

    // single request, frame held while the input changes
    e0 = ena_cnt;
    push(2'd0, 1'b0);
    pend[0] = 1;
    wait_ena(e0, 10);
    chk("lat_ena", W'(ena_cyc - req_cyc + 1), W'(2));
    wait_busy(10);
    repeat (10) @(negedge clk_1MHz);
    r1[0] = WORLD;
    repeat (5) @(negedge clk_1MHz);
    chk("row_hold", lcd_row1, HELLO);
    wait_drain(400);
    chk("done_lat", W'(done_cyc - fall_cyc), W'(1));
    chk("single_ena", W'(ena_cnt - e0), W'(1));

    // contention from rr_ptr=0
    rst_n = 1'b0;
    @(negedge clk_1MHz);
    rst_n = 1'b1;
    busy_len = 5;
    push(2'd0, 1'b0);
    push(2'd1, 1'b0);
    push(2'd2, 1'b0);
    push(2'd3, 1'b0);
    push(2'd0, 1'b0);
    pend[0] = 2;
    pend[1] = 1;
    pend[2] = 1;
    pend[3] = 1;
    wait_drain(500);

    // wrap past absent requester 3
    push(2'd2, 1'b0);
    pend[2] = 1;
    wait_drain(100);
    push(2'd0, 1'b0);
    push(2'd2, 1'b0);
    pend[0] = 1;
    pend[2] = 1;
    wait_drain(200);

    // driver never starts
    mute = 1'b1;
    e0 = ena_cnt;
    push(2'd1, 1'b1);
    pend[1] = 1;
    wait_drain(100);
    chk("tmo_lat", W'(done_cyc - ena_cyc), W'(17));
    chk("tmo_ena_once", W'(ena_cnt - e0), W'(1));
    mute = 1'b0;

    // reset during WAIT_DONE
    busy_len = 40;
    e0 = ena_cnt;
    d0 = dn_cnt;
    pend[3] = 1;
    wait_busy(20);
    repeat (5) @(negedge clk_1MHz);
    pend[3] = 0;
    rst_n = 1'b0;
    @(negedge clk_1MHz);
    chk("mrst_grant", W'(grant), W'(0));
    chk("mrst_ena", W'(lcd_ena), W'(0));
    chk("mrst_done", W'(done), W'(0));
    chk("mrst_row1", lcd_row1, W'(0));
    rst_n = 1'b1;
    repeat (60) @(negedge clk_1MHz);
    chk("mrst_no_done", W'(dn_cnt - d0), W'(0));
    chk("mrst_ena_cnt", W'(ena_cnt - e0), W'(1));

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_arbiter.md
Name: lcd_arbiter

Overview:
- Shares one LCD_DRIVER instance (16x2 character LCD over I2C) among N_REQ independent requesters, each of which supplies a full two-row frame.
- Arbitrates round-robin and latches the granted frame onto the driver's row1/row2 inputs.
- Issues a single-cycle lcd_ena and tracks the driver's busy signal through to completion.
- Returns a per-requester done pulse, or a timeout error if the driver never starts.
- Sits between application modules (clock display, menu, status) and LCD_DRIVER.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- START_TMO, 16, clk_1MHz cycles to wait for lcd_busy to rise after lcd_ena before aborting.
- PW, 2, pointer width; must equal clog2(N_REQ).

Ports:
- clk_1MHz  in  1  system clock for this block and the LCD driver.
- rst_n  in  1  synchronous active-low reset.
- req  in  N_REQ  per-requester level request; held high until the matching done pulse.
- row1_in  in  N_REQ*128  packed row-1 frames; requester i occupies bits [128*i+127:128*i].
- row2_in  in  N_REQ*128  packed row-2 frames, same packing.
- grant  out  N_REQ  one-hot; the requester currently owning the driver.
- done  out  N_REQ  one-cycle pulse to the owner when its frame has finished.
- err_tmo  out  1  one-cycle pulse, coincident with done, when the transfer was aborted on timeout.
- lcd_ena  out  1  one-cycle start strobe to LCD_DRIVER.
- lcd_row1  out  128  latched row-1 frame to LCD_DRIVER.
- lcd_row2  out  128  latched row-2 frame to LCD_DRIVER.
- lcd_busy  in  1  busy output of LCD_DRIVER.

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE, grant=0, done=0, err_tmo=0, lcd_ena=0, lcd_row1=lcd_row2=0, rr_ptr=0, timeout counter=0.
- Reset asserted mid-transfer aborts immediately. No done is issued. The driver is left to finish on its own.
- FSM states:
  - IDLE: wait until req!=0 and lcd_busy==0. Select the winner by round-robin: search from index rr_ptr upward with wrap, first set bit wins. Register grant, lcd_row1/lcd_row2 from the winner's slice, and owner index. Go to START.
  - START: lcd_ena=1 for exactly this one cycle. Clear the timeout counter. Go to WAIT_BUSY.
  - WAIT_BUSY:
    - lcd_busy==1: go to WAIT_DONE.
    - Counter reaches START_TMO-1 with lcd_busy still 0: go to FINISH with the error flag set.
    - Otherwise: increment the counter.
  - WAIT_DONE: remain while lcd_busy==1. On lcd_busy==0, go to FINISH.
  - FINISH: done[owner]=1 for one cycle; err_tmo=1 if the error flag is set. grant=0. rr_ptr=owner+1, wrapping to 0 at N_REQ. Clear the error flag. Go to IDLE.
- Latency, request to lcd_ena: 2 cycles when the driver is idle (IDLE register cycle, then START).
- Minimum inter-transfer gap: 1 idle cycle after FINISH.
- lcd_row1/lcd_row2 hold constant from grant until the next grant; they do not follow row*_in changes during a transfer.
- A requester dropping req while granted does not abort the transfer; done still pulses.
- A requester's req bit still high in the cycle after its done is treated as a new request.
- lcd_busy already high in IDLE (driver still busy from a prior aborted transfer) blocks arbitration until it falls.
- Simultaneous requests: only the round-robin winner is granted; the others wait. No requester waits more than N_REQ-1 transfers.
- N_REQ=1 degenerates to a fixed grant with rr_ptr always 0.

Decomposition:
- Package lcd_pkg holds:
  - the state encoding (IDLE, START, WAIT_BUSY, WAIT_DONE, FINISH, 3-bit);
  - LCD_ROW_W=128;
  - the default START_TMO.
- One sub-module, rr_picker: combinational round-robin priority encoder. Inputs req and rr_ptr; outputs one-hot grant and binary index. Instantiated once.

Test Plan:
- Single request: req=0001 with driver model busy for 200 cycles → lcd_ena pulses 2 cycles after req; lcd_row1 equals row1_in slice 0; done=0001 one cycle after busy falls; err_tmo=0.
- Contention: req=1111 held, rr_ptr=0 → grants in order 0001, 0010, 0100, 1000, 0001; each done is one-hot to the matching requester.
- Fairness after wrap: after requester 2 is served, req=0101 → grant 0001? No: requester 3 is absent, so the pointer wraps and the next grant is 0001, then 0100.
- Timeout: driver model never raises busy, START_TMO=16 → done[owner] and err_tmo pulse exactly 17 cycles after lcd_ena; lcd_ena is not reissued.
- Frame stability: row1_in[0] changes from "HELLO" to "WORLD" during WAIT_DONE → lcd_row1 keeps "HELLO" until the next grant.
- Mid-transfer reset: rst_n=0 for one edge during WAIT_DONE → next cycle grant=0, lcd_ena=0, done=0, state=IDLE; no done pulse is emitted afterward.
